can_fault_confine: RTL
======================

// Module: can_fault_confine
// PURPOSE
//  Combined CAN fault-confinement block: receive (REC) and transmit (TEC) error counters
//  plus the ERROR_ACTIVE / ERROR_PASSIVE / BUS_OFF state machine and bus-off recovery.
//  Sits between the MAC FSM (count requests, 11-recessive-bit detector) and the LLC/register
//  interface. Replaces the separate REC/TEC/fault-FSM blocks.
// PARAMETERS
//  CNT_W       9    counter width; MSB is the overflow/bus-off flag
//  WARN_LIM    96   warning threshold for either counter (>=)
//  PASS_LIM    128  error-passive threshold for either counter (>=)
//  BOFF_LIM    256  TEC bus-off threshold (>=); must be < 2**CNT_W
//  STEP_HI     8    increment for incegtrec / incegttec
//  REC_REWIND  120  REC load value on decrec while REC >= PASS_LIM (119..127)
//  RECOV_OCC   128  idle11 occurrences needed to leave BUS_OFF
// PORTS
//  clock        in   1        system clock, posedge
//  reset        in   1        asynchronous, active-low; clears all state
//  inconerec    in   1        MAC: REC +1 (level, counted once per rising edge)
//  incegtrec    in   1        MAC: REC +STEP_HI
//  decrec       in   1        MAC: REC -1 / rewind
//  incegttec    in   1        MAC: TEC +STEP_HI
//  dectec       in   1        MAC: TEC -1
//  idle11       in   1        MAC: one 11-recessive-bit sequence seen (level, edge-counted)
//  reccount     out  CNT_W-1  REC value (recovery progress while BUS_OFF)
//  teccount     out  CNT_W-1  TEC value, low bits
//  warning      out  1        REC or TEC >= WARN_LIM
//  erroractive  out  1        state == ERROR_ACTIVE
//  errorpassive out  1        state == ERROR_PASSIVE
//  busoff       out  1        state == BUS_OFF
//  state_chg    out  1        one-cycle pulse on any state transition
// BEHAVIOUR
//  - Reset: counters 0, edge flags 0, state ERROR_ACTIVE; erroractive=1, all other outputs 0.
//  - Edge detection per counter: a request group acts only on the first clock where any of its
//    requests is high after a cycle with all low; held levels do not recount. REC group =
//    {inconerec,incegtrec,decrec}, TEC group = {incegttec,dectec}, idle11 its own.
//  - Latency: counter and all status outputs update on the same posedge that samples the edge.
//  - REC priority in one edge: decrec > inconerec > incegtrec. decrec at 0: no change.
//    decrec with REC >= PASS_LIM: REC <= REC_REWIND. Increments saturate at BOFF_LIM-1;
//    REC never causes BUS_OFF.
//  - TEC priority: dectec > incegttec. dectec at 0: no change. TEC saturates at 2**CNT_W-1.
//  - REC and TEC update independently in the same cycle; state uses both next values.
//  - FSM (next values, evaluated every cycle):
//    ERROR_ACTIVE  -> BUS_OFF if TEC>=BOFF_LIM; else ERROR_PASSIVE if REC or TEC >= PASS_LIM
//    ERROR_PASSIVE -> BUS_OFF if TEC>=BOFF_LIM; ERROR_ACTIVE if both < PASS_LIM
//    BUS_OFF       -> ERROR_ACTIVE when recovery count reaches RECOV_OCC
//  - Entering BUS_OFF: REC cleared to 0 and reused as recovery counter; TEC frozen.
//    All MAC count requests ignored in BUS_OFF; each idle11 edge increments REC.
//    On RECOV_OCC-th edge: REC<=0, TEC<=0, state ERROR_ACTIVE, state_chg pulses.
//  - idle11 ignored outside BUS_OFF.
//  - warning computed from counters in ERROR_ACTIVE/PASSIVE; forced 0 in BUS_OFF.
//  - Reset asserted mid-operation (incl. BUS_OFF recovery): immediate clear, no state_chg.
// STRUCTURE
//  - Package can_fc_pkg: state encoding constants (FC_ACTIVE=2'd0, FC_PASSIVE=2'd1,
//    FC_BUSOFF=2'd2), default threshold constants.
//  - Sub-module can_errcnt_core: edge detect + inc-one/inc-step/dec/rewind/saturate/clear for
//    one counter; instanced twice (REC with rewind enabled, TEC without). FSM and recovery
//    logic in the top.
// TESTING
//  1. Reset, 12 incegtrec edges -> REC 96, warning=1 at edge 12, erroractive=1.
//  2. REC at 127 + inconerec -> REC 128, errorpassive=1, state_chg 1 cycle; then decrec ->
//     REC 120, erroractive=1.
//  3. incegttec held high 5 cycles -> TEC +8 once only; 32 edges from 0 -> TEC 256,
//     busoff=1, reccount=0.
//  4. In BUS_OFF: 127 idle11 edges -> reccount 127, busoff=1; 128th -> REC=TEC=0,
//     erroractive=1, state_chg pulse; inconerec during BUS_OFF has no effect.
//  5. Same-cycle edges: decrec+inconerec at REC=5 -> REC 4; incegttec+decrec at TEC=120,
//     REC=0 -> TEC 128, REC 0, errorpassive=1.
//  6. Reset low asynchronously mid-recovery (reccount 60) -> all outputs reset value
//     before next clock edge.

Source files
------------

// File: rtl/can_fc_pkg.sv
// Shared state encoding and default thresholds for the CAN fault-confinement block.
package can_fc_pkg;

  typedef enum logic [1:0] {
    FC_ACTIVE  = 2'd0,
    FC_PASSIVE = 2'd1,
    FC_BUSOFF  = 2'd2
  } fc_state_e;

  localparam int unsigned DEF_CNT_W      = 9;
  localparam int unsigned DEF_WARN_LIM   = 96;
  localparam int unsigned DEF_PASS_LIM   = 128;
  localparam int unsigned DEF_BOFF_LIM   = 256;
  localparam int unsigned DEF_STEP_HI    = 8;
  localparam int unsigned DEF_REC_REWIND = 120;
  localparam int unsigned DEF_RECOV_OCC  = 128;

endpackage

// File: rtl/can_errcnt_core.sv
// One CAN error counter: group edge detect, +1 / +step / -1 / rewind, saturation and clear.
module can_errcnt_core
  import can_fc_pkg::*;
#(
  parameter int unsigned CntW      = DEF_CNT_W,
  parameter int unsigned StepHi    = DEF_STEP_HI,
  parameter int unsigned SatMax    = DEF_BOFF_LIM - 1,
  parameter bit          RewindEn  = 1'b0,
  parameter int unsigned RewindLim = DEF_PASS_LIM,
  parameter int unsigned RewindVal = DEF_REC_REWIND
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            inc_one,
  input  logic            inc_step,
  input  logic            dec,
  input  logic            enable,
  input  logic            clear,
  input  logic            bump,
  output logic [CntW-1:0] cnt,
  output logic [CntW-1:0] cnt_next
);

  localparam logic [CntW:0]   SatW    = (CntW+1)'(SatMax);
  localparam logic [CntW:0]   StepW   = (CntW+1)'(StepHi);
  localparam logic [CntW:0]   OneW    = (CntW+1)'(1);
  localparam logic [CntW-1:0] OneN    = CntW'(1);
  localparam logic [CntW-1:0] RewLimW = CntW'(RewindLim);
  localparam logic [CntW-1:0] RewValW = CntW'(RewindVal);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW:0]   cnt_ext;
  logic            prev_q;
  logic            any_req;
  logic            fire;

  function automatic logic [CntW-1:0] sat(input logic [CntW:0] sum);
    return (sum > SatW) ? SatW[CntW-1:0] : sum[CntW-1:0];
  endfunction

  assign cnt_ext = {1'b0, cnt_q};
  assign any_req = inc_one | inc_step | dec;
  assign fire    = any_req & ~prev_q & enable;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (bump) begin
      cnt_d = sat(cnt_ext + OneW);
    end else if (fire) begin
      // Within one edge: decrement beats +1, which beats +step.
      if (dec) begin
        if (cnt_q != '0) begin
          if (RewindEn && (cnt_q >= RewLimW)) cnt_d = RewValW;
          else                                cnt_d = cnt_q - OneN;
        end
      end else if (inc_one) begin
        cnt_d = sat(cnt_ext + OneW);
      end else begin
        cnt_d = sat(cnt_ext + StepW);
      end
    end
  end

  // Edge flag tracks the raw group level even while counting is disabled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      prev_q <= any_req;
    end
  end

  assign cnt      = cnt_q;
  assign cnt_next = cnt_d;

endmodule

// File: rtl/can_fault_confine.sv
// CAN fault confinement: REC/TEC counters, active/passive/bus-off FSM and bus-off recovery.
module can_fault_confine
  import can_fc_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned WARN_LIM   = DEF_WARN_LIM,
  parameter int unsigned PASS_LIM   = DEF_PASS_LIM,
  parameter int unsigned BOFF_LIM   = DEF_BOFF_LIM,
  parameter int unsigned STEP_HI    = DEF_STEP_HI,
  parameter int unsigned REC_REWIND = DEF_REC_REWIND,
  parameter int unsigned RECOV_OCC  = DEF_RECOV_OCC
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inconerec,
  input  logic             incegtrec,
  input  logic             decrec,
  input  logic             incegttec,
  input  logic             dectec,
  input  logic             idle11,
  output logic [CNT_W-2:0] reccount,
  output logic [CNT_W-2:0] teccount,
  output logic             warning,
  output logic             erroractive,
  output logic             errorpassive,
  output logic             busoff,
  output logic             state_chg
);

  localparam logic [CNT_W-1:0] WarnW      = CNT_W'(WARN_LIM);
  localparam logic [CNT_W-1:0] PassW      = CNT_W'(PASS_LIM);
  localparam logic [CNT_W-1:0] BoffW      = CNT_W'(BOFF_LIM);
  localparam logic [CNT_W-1:0] RecovLastW = CNT_W'(RECOV_OCC - 1);

  fc_state_e        state_q, state_d;
  logic [CNT_W-1:0] rec_q, rec_d, tec_q, tec_d;
  logic             idle_prev_q;
  logic             idle_fire;
  logic             recov_done;
  logic             enter_boff;
  logic             count_en;
  logic             warn_d;
  logic             unused_tec_msb;

  assign count_en   = (state_q != FC_BUSOFF);
  assign idle_fire  = idle11 & ~idle_prev_q & ~count_en;
  assign recov_done = idle_fire & (rec_q == RecovLastW);
  assign enter_boff = count_en & (tec_d >= BoffW);

  // REC doubles as the idle11 recovery counter while bus-off.
  can_errcnt_core #(
    .CntW      (CNT_W),
    .StepHi    (STEP_HI),
    .SatMax    (BOFF_LIM - 1),
    .RewindEn  (1'b1),
    .RewindLim (PASS_LIM),
    .RewindVal (REC_REWIND)
  ) u_rec (
    .clock    (clock),
    .reset    (reset),
    .inc_one  (inconerec),
    .inc_step (incegtrec),
    .dec      (decrec),
    .enable   (count_en),
    .clear    (enter_boff | recov_done),
    .bump     (idle_fire),
    .cnt      (rec_q),
    .cnt_next (rec_d)
  );

  can_errcnt_core #(
    .CntW      (CNT_W),
    .StepHi    (STEP_HI),
    .SatMax    ((2 ** CNT_W) - 1),
    .RewindEn  (1'b0),
    .RewindLim (PASS_LIM),
    .RewindVal (REC_REWIND)
  ) u_tec (
    .clock    (clock),
    .reset    (reset),
    .inc_one  (1'b0),
    .inc_step (incegttec),
    .dec      (dectec),
    .enable   (count_en),
    .clear    (recov_done),
    .bump     (1'b0),
    .cnt      (tec_q),
    .cnt_next (tec_d)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FC_ACTIVE, FC_PASSIVE: begin
        if (tec_d >= BoffW)                          state_d = FC_BUSOFF;
        else if ((rec_d >= PassW) || (tec_d >= PassW)) state_d = FC_PASSIVE;
        else                                         state_d = FC_ACTIVE;
      end
      FC_BUSOFF: begin
        if (recov_done) state_d = FC_ACTIVE;
      end
      default: state_d = FC_ACTIVE;
    endcase
  end

  assign warn_d = (state_d != FC_BUSOFF) && ((rec_d >= WarnW) || (tec_d >= WarnW));

  // Status flags are registered from next-state values so they move with the counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= FC_ACTIVE;
      idle_prev_q  <= 1'b0;
      warning      <= 1'b0;
      erroractive  <= 1'b1;
      errorpassive <= 1'b0;
      busoff       <= 1'b0;
      state_chg    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle_prev_q  <= idle11;
      warning      <= warn_d;
      erroractive  <= (state_d == FC_ACTIVE);
      errorpassive <= (state_d == FC_PASSIVE);
      busoff       <= (state_d == FC_BUSOFF);
      state_chg    <= (state_d != state_q);
    end
  end

  assign reccount       = rec_q[CNT_W-2:0];
  assign teccount       = tec_q[CNT_W-2:0];
  assign unused_tec_msb = tec_q[CNT_W-1];

endmodule
